stream_denormalizer: RTL

- Splits a dense AXI4S byte stream into output beats whose byte counts come from a separate length command stream.
- Each output beat carries its bytes LSB-aligned, with tkeep set to a contiguous run of low ones.
- Placed after decompression/DMA read paths, where downstream consumers expect fixed or variable sparse beat widths.
- Performs the inverse of the packing normalizer: dense in, sparse out.

---
 rtl/stream_denormalizer_if.sv | 21 ++
 rtl/stream_denormalizer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/stream_denormalizer_if.sv
// AXI4-Stream bundle (tdata/tkeep/tlast/tvalid/tready) shared by the
// dense input and the sparse output of stream_denormalizer.
interface stream_denormalizer_if #(
   parameter int WIDTH = 512
);
   logic [WIDTH-1:0]   tdata;
   logic [WIDTH/8-1:0] tkeep;
   logic               tlast;
   logic               tvalid;
   logic               tready;

   modport master (
      output tdata, tkeep, tlast, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tlast, tvalid,
      output tready
   );
endinterface

// File: rtl/stream_denormalizer.sv
// Re-cuts a dense AXI4S byte stream into LSB-aligned beats sized by a length stream.
// Define STREAM_DENORM_LEN_CHECK_EN to build the sticky o_len_err illegal-length flag.
module stream_denormalizer #(
   parameter int WIDTH = 512,
   localparam int BYTES = WIDTH / 8,
   localparam int LEN_W = $clog2(BYTES) + 1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   stream_denormalizer_if.slave  i_data,
   input  logic                  i_len_valid,
   output logic                  i_len_ready,
   input  logic [LEN_W-1:0]      i_len,
   stream_denormalizer_if.master o_data,
   output logic                  o_len_err
);
   localparam int BUF_B = 2 * BYTES;
   localparam int BUF_W = 8 * BUF_B;
   localparam int CW    = $clog2(BUF_B + 1);

   logic [BUF_W-1:0] r_buf;
   logic [CW-1:0]    r_cnt;
   logic             r_last_held;
   logic [WIDTH-1:0] r_tdata;
   logic [BYTES-1:0] r_tkeep;
   logic             r_tlast;
   logic             r_tvalid;

   logic             w_len_ok;
   logic [CW-1:0]    w_eff;
   logic             w_load;
   logic [CW-1:0]    w_take;
   logic [CW-1:0]    w_cons;
   logic [CW-1:0]    w_left;
   logic             w_in_rdy;
   logic             w_acc;
   logic             w_tlast;
   logic [CW-1:0]    w_nin;
   logic [WIDTH-1:0] w_kmask;
   logic [BYTES-1:0] w_okeep;
   logic [WIDTH-1:0] w_omask;
   logic [BUF_W-1:0] w_shift;
   logic [BUF_W-1:0] w_app;

   assign w_len_ok = (i_len != '0) && (i_len <= LEN_W'(BYTES));
   assign w_eff    = w_len_ok ? CW'(i_len) : CW'(BYTES);

   // A held packet end forces a (possibly short) beat regardless of length.
   assign w_load   = (!r_tvalid || o_data.tready) && i_len_valid &&
                     ((r_cnt >= w_eff) || r_last_held);
   assign w_take   = (r_cnt < w_eff) ? r_cnt : w_eff;
   assign w_cons   = w_load ? w_take : '0;
   assign w_left   = r_cnt - w_cons;
   assign w_tlast  = r_last_held && (r_cnt <= w_eff);

   // Next packet waits until the held last byte has gone out.
   assign w_in_rdy = !r_last_held && (w_left <= CW'(BYTES));
   assign w_acc    = i_data.tvalid && w_in_rdy;

   always_comb begin
      w_nin   = '0;
      w_kmask = '0;
      w_okeep = '0;
      w_omask = '0;
      for (int i = 0; i < BYTES; i++) begin
         w_nin             = w_nin + CW'(i_data.tkeep[i]);
         w_kmask[i*8 +: 8] = {8{i_data.tkeep[i]}};
         w_okeep[i]        = CW'(i) < w_take;
         w_omask[i*8 +: 8] = {8{w_okeep[i]}};
      end
   end

   // Bytes above cnt stay zero, so append is a plain OR.
   assign w_shift = r_buf >> {w_cons, 3'b000};
   assign w_app   = {{WIDTH{1'b0}}, i_data.tdata & w_kmask}
                    << {w_left, 3'b000};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_buf       <= '0;
         r_cnt       <= '0;
         r_last_held <= 1'b0;
      end else begin
         r_buf <= w_acc ? (w_shift | w_app) : w_shift;
         r_cnt <= w_left + (w_acc ? w_nin : '0);
         if (w_load && w_tlast)
            r_last_held <= 1'b0;
         else if (w_acc && i_data.tlast)
            r_last_held <= 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
      end else if (w_load) begin
         r_tdata  <= r_buf[WIDTH-1:0] & w_omask;
         r_tkeep  <= w_okeep;
         r_tlast  <= w_tlast;
         r_tvalid <= 1'b1;
      end else if (o_data.tready) begin
         r_tvalid <= 1'b0;
      end
   end

`ifdef STREAM_DENORM_LEN_CHECK_EN
   logic r_len_err;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         r_len_err <= 1'b0;
      else if (w_load && !w_len_ok)
         r_len_err <= 1'b1;
   end

   assign o_len_err = r_len_err;
`else
   assign o_len_err = 1'b0;
`endif

   assign i_len_ready   = w_load;
   assign i_data.tready = w_in_rdy;
   assign o_data.tdata  = r_tdata;
   assign o_data.tkeep  = r_tkeep;
   assign o_data.tlast  = r_tlast;
   assign o_data.tvalid = r_tvalid;
endmodule
